execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage RV32I pipeline, sitting between the decode/ID-EX register and the memory stage. It resolves operand forwarding, computes the ALU result, and resolves branches and jumps within the same cycle. It drives the EX/MEM pipeline register, whose outputs feed the memory stage. An optional iterative multiplier stalls the front end while it runs.

## Interface
- No parameters.
- i_clk  in  1  core clock
- i_rst  in  1  reset; asynchronous, active-high
- i_stall_e  in  1  hold the EX/MEM register (memory-side stall)
- i_flush_e  in  1  insert a bubble into EX/MEM; abort any multiply
- i_rd_wren_e, i_mem_wren_e  in  1  control signals passed through to MEM
- i_wb_sel_e  in  2  writeback select, passed through
- i_funct3_e  in  3  branch condition / load-store size / multiply variant
- i_rd_e  in  5  destination register
- i_alu_op_e  in  4  ALU operation
- i_op_a_sel_e  in  1  operand A: 0 = rs1, 1 = pc
- i_op_b_sel_e  in  1  operand B: 0 = rs2, 1 = imm
- i_br_e, i_jmp_e, i_mul_e  in  1  branch, jump, and multiply instruction flags
- i_fwd_a_sel, i_fwd_b_sel  in  2  forwarding select: 00 = regfile, 01 = o_alu_data_m, 10 = i_wb_data_w, 11 = regfile
- i_pc_e, i_imm_e, i_rs1_data_e, i_rs2_data_e, i_wb_data_w  in  32  datapath inputs
- o_rd_wren_m, o_mem_wren_m  out  1  registered control outputs
- o_wb_sel_m  out  2  registered writeback select
- o_funct3_m  out  3  registered funct3
- o_rd_m  out  5  registered destination register
- o_pc_four_m, o_alu_data_m, o_st_data_m  out  32  registered datapath outputs
- o_br_taken_e  out  1  combinational redirect request
- o_br_target_e  out  32  combinational redirect target
- o_busy_e  out  1  multiplier busy; hazard unit stalls IF/ID/EX while this is high

## Operation
- **Forwarding:** fwd_a and fwd_b are selected by i_fwd_*_sel.
  - Operand A is fwd_a or pc.
  - Operand B is fwd_b or imm.
- **ALU ops:**
  - 0 = ADD, 1 = SUB, 2 = SLL, 3 = SLT, 4 = SLTU, 5 = XOR, 6 = SRL, 7 = SRA, 8 = OR, 9 = AND, 10 = pass B (LUI).
  - Codes 11–15 produce 0.
  - Shift amounts use B[4:0]. All arithmetic wraps mod 2^32.
- **Branch compare:** uses fwd_a vs fwd_b, selected by funct3.
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- **Redirect:** o_br_taken_e = ((i_br_e & cond) | i_jmp_e) & ~i_flush_e.
- **Target:**
  - Jump with op_a_sel = 0 (JALR): {alu[31:1], 1'b0}.
  - Otherwise: i_pc_e + i_imm_e.
- **EX/MEM register contents:**
  - o_alu_data_m = ALU result, or the multiply result when a multiply completes.
  - o_st_data_m = fwd_b.
  - o_pc_four_m = i_pc_e + 4.
- **EX/MEM register update priority:**
  1. Reset: all outputs 0.
  2. i_stall_e: hold.
  3. i_flush_e or o_busy_e: bubble. rd_wren = 0 and mem_wren = 0; other fields 0.
  4. Otherwise: load.

## Timing
- ALU, load and store paths have a latency of 1 cycle: data appears on *_m one edge after the instruction is presented.
- o_br_taken_e and o_br_target_e are valid in the same cycle as the instruction.
- Forwarding path 01 uses this block's own registered o_alu_data_m.
- Multiplier FSM (macro on): states IDLE, RUN, DONE.
  - **IDLE → RUN:** on i_mul_e & ~i_flush_e. Operand magnitudes and signs are latched; counter = 0.
  - **RUN:** one radix-2 shift-add step per cycle for 32 cycles, then → DONE.
  - **DONE:** sign-correct the product and select the half by funct3: 000 low, 001 MULH, 010 MULHSU, 011 MULHU.
  - **DONE with i_stall_e high:** remain in DONE and hold the result.
  - **DONE otherwise:** load EX/MEM, then → IDLE.
  - o_busy_e = 1 in the issue cycle and in all of RUN, i.e. 33 cycles; 0 in DONE. The result is in o_alu_data_m 34 edges after issue.
  - Upstream holds the ID/EX inputs stable while o_busy_e = 1.
  - i_flush_e in any state → IDLE; no result is written.
  - i_rst mid-multiply → IDLE, counter 0, o_busy_e 0.

## Configuration
- Macro: EXECUTE_MUL_EN.
- **Defined:** the multiplier FSM is compiled in and funct3 000–011 are honoured for i_mul_e.
- **Undefined:** the FSM is removed, i_mul_e is ignored, o_busy_e is tied to 0, and the instruction executes as a plain i_alu_op_e operation.

## Test plan
- ADD: rs1 = 0x7FFFFFFF, rs2 = 1, alu_op 0 → o_alu_data_m = 0x80000000 after 1 edge; SRA of 0x80000000 by 4 → 0xF8000000.
- Forwarding: fwd_a_sel = 01 after the previous ADD produced 5, rs2 = 3, SUB → 2; fwd_b_sel = 10 with i_wb_data_w = 9 → o_st_data_m = 9.
- Branches:
  - BLT with rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x100, imm = 0x20 → taken, target 0x120.
  - BLTU with the same operands → not taken.
  - JALR with rs1 = 0x203, imm = 0 → target 0x202.
- Stall/flush: stall held 3 cycles → *_m unchanged; flush → o_rd_wren_m = 0 and o_mem_wren_m = 0; o_br_taken_e = 0 while flushing.
- MUL (macro on):
  - funct3 000, 0xFFFFFFFF × 2 → o_busy_e high for 33 cycles, then o_alu_data_m = 0xFFFFFFFE.
  - funct3 001 with the same operands → 0xFFFFFFFF.
  - funct3 011 with the same operands → 1.
  - Bubbles are emitted during busy.
- Abort: i_flush_e at RUN cycle 10 → IDLE, o_busy_e low next cycle, no write; i_rst pulse mid-RUN → all outputs 0.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage. Operand forwarding, ALU, same-cycle
// branch/jump resolution and the EX/MEM pipeline register.
// Define EXECUTE_MUL_EN to build in the iterative radix-2 multiplier
// (MUL/MULH/MULHSU/MULHU), which stalls the front end while it runs.

module execute_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_e,
    input  logic        i_flush_e,
    input  logic        i_rd_wren_e,
    input  logic        i_mem_wren_e,
    input  logic [1:0]  i_wb_sel_e,
    input  logic [2:0]  i_funct3_e,
    input  logic [4:0]  i_rd_e,
    input  logic [3:0]  i_alu_op_e,
    input  logic        i_op_a_sel_e,
    input  logic        i_op_b_sel_e,
    input  logic        i_br_e,
    input  logic        i_jmp_e,
    input  logic        i_mul_e,
    input  logic [1:0]  i_fwd_a_sel,
    input  logic [1:0]  i_fwd_b_sel,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_imm_e,
    input  logic [31:0] i_rs1_data_e,
    input  logic [31:0] i_rs2_data_e,
    input  logic [31:0] i_wb_data_w,
    output logic        o_rd_wren_m,
    output logic        o_mem_wren_m,
    output logic [1:0]  o_wb_sel_m,
    output logic [2:0]  o_funct3_m,
    output logic [4:0]  o_rd_m,
    output logic [31:0] o_pc_four_m,
    output logic [31:0] o_alu_data_m,
    output logic [31:0] o_st_data_m,
    output logic        o_br_taken_e,
    output logic [31:0] o_br_target_e,
    output logic        o_busy_e
);

    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
    logic        br_cond;
    logic        busy, mul_done;
    logic [31:0] mul_res;

    // Forwarding muxes: own EX/MEM result, writeback data, or register file
    always_comb begin
        case (i_fwd_a_sel)
            2'b01:   fwd_a = o_alu_data_m;
            2'b10:   fwd_a = i_wb_data_w;
            default: fwd_a = i_rs1_data_e;
        endcase
        case (i_fwd_b_sel)
            2'b01:   fwd_b = o_alu_data_m;
            2'b10:   fwd_b = i_wb_data_w;
            default: fwd_b = i_rs2_data_e;
        endcase
        op_a = i_op_a_sel_e ? i_pc_e  : fwd_a;
        op_b = i_op_b_sel_e ? i_imm_e : fwd_b;
    end

    // ALU
    always_comb begin
        alu_res = '0;
        case (i_alu_op_e)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << op_b[4:0];
            4'd3:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_res = {31'd0, op_a < op_b};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> op_b[4:0];
            4'd7:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition on the forwarded register operands
    always_comb begin
        br_cond = 1'b0;
        case (i_funct3_e)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a <  fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign o_br_taken_e  = ((i_br_e & br_cond) | i_jmp_e) & ~i_flush_e;
    assign o_br_target_e = (i_jmp_e & ~i_op_a_sel_e) ? {alu_res[31:1], 1'b0}
                                                     : i_pc_e + i_imm_e;

`ifdef EXECUTE_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

    mul_state_t  state_q, state_d;
    logic        issue;
    logic [4:0]  cnt_q;
    logic [1:0]  f3_q;
    logic        neg_q;
    logic [31:0] mag_a_q;
    logic [63:0] prod_q;
    logic        sgn_a, sgn_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] step_sum;
    logic [63:0] prod_fix;

    assign issue = (state_q == S_IDLE) & i_mul_e & ~i_flush_e;

    // Multiplier state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Multiplier next state; a flush aborts from any state
    always_comb begin
        state_d = state_q;
        if (i_flush_e) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (i_mul_e)         state_d = S_RUN;
                S_RUN:   if (cnt_q == 5'd31)  state_d = S_DONE;
                S_DONE:  if (!i_stall_e)      state_d = S_IDLE;
                default:                      state_d = S_IDLE;
            endcase
        end
    end

    // Multiplier outputs: busy through issue and RUN, result select in DONE
    always_comb begin
        busy     = issue | (state_q == S_RUN);
        mul_done = (state_q == S_DONE);
        prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;
        mul_res  = (f3_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end

    // Operand sign/magnitude split and one shift-add step
    always_comb begin
        sgn_a    = (i_funct3_e[1:0] != 2'b11) & fwd_a[31];
        sgn_b    = ~i_funct3_e[1] & fwd_b[31];
        mag_a    = sgn_a ? (~fwd_a + 32'd1) : fwd_a;
        mag_b    = sgn_b ? (~fwd_b + 32'd1) : fwd_b;
        step_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mag_a_q} : 33'd0);
    end

    // Multiplier datapath: latch magnitudes on issue, accumulate in RUN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            mag_a_q <= '0;
            prod_q  <= '0;
        end else if (issue) begin
            cnt_q   <= '0;
            f3_q    <= i_funct3_e[1:0];
            neg_q   <= sgn_a ^ sgn_b;
            mag_a_q <= mag_a;
            prod_q  <= {32'd0, mag_b};
        end else if (state_q == S_RUN) begin
            cnt_q   <= cnt_q + 5'd1;
            prod_q  <= {step_sum, prod_q[31:1]};
        end
    end
`else
    logic mul_unused;
    assign mul_unused = i_mul_e;
    assign busy       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_res    = '0;
`endif

    assign o_busy_e = busy;

    // EX/MEM register: reset, hold on stall, bubble on flush/busy, else load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_wren_m  <= 1'b0;
            o_mem_wren_m <= 1'b0;
            o_wb_sel_m   <= '0;
            o_funct3_m   <= '0;
            o_rd_m       <= '0;
            o_pc_four_m  <= '0;
            o_alu_data_m <= '0;
            o_st_data_m  <= '0;
        end else if (i_stall_e) begin
            o_rd_wren_m  <= o_rd_wren_m;
        end else if (i_flush_e | busy) begin
            o_rd_wren_m  <= 1'b0;
            o_mem_wren_m <= 1'b0;
            o_wb_sel_m   <= '0;
            o_funct3_m   <= '0;
            o_rd_m       <= '0;
            o_pc_four_m  <= '0;
            o_alu_data_m <= '0;
            o_st_data_m  <= '0;
        end else begin
            o_rd_wren_m  <= i_rd_wren_e;
            o_mem_wren_m <= i_mem_wren_e;
            o_wb_sel_m   <= i_wb_sel_e;
            o_funct3_m   <= i_funct3_e;
            o_rd_m       <= i_rd_e;
            o_pc_four_m  <= i_pc_e + 32'd4;
            o_alu_data_m <= mul_done ? mul_res : alu_res;
            o_st_data_m  <= fwd_b;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.

module tb_execute_stage;

`ifdef EXECUTE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic        i_clk, i_rst;
    logic        i_stall_e, i_flush_e, i_rd_wren_e, i_mem_wren_e;
    logic [1:0]  i_wb_sel_e;
    logic [2:0]  i_funct3_e;
    logic [4:0]  i_rd_e;
    logic [3:0]  i_alu_op_e;
    logic        i_op_a_sel_e, i_op_b_sel_e, i_br_e, i_jmp_e, i_mul_e;
    logic [1:0]  i_fwd_a_sel, i_fwd_b_sel;
    logic [31:0] i_pc_e, i_imm_e, i_rs1_data_e, i_rs2_data_e, i_wb_data_w;
    logic        o_rd_wren_m, o_mem_wren_m;
    logic [1:0]  o_wb_sel_m;
    logic [2:0]  o_funct3_m;
    logic [4:0]  o_rd_m;
    logic [31:0] o_pc_four_m, o_alu_data_m, o_st_data_m;
    logic        o_br_taken_e;
    logic [31:0] o_br_target_e;
    logic        o_busy_e;

    int total, bad;

    execute_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall_e(i_stall_e), .i_flush_e(i_flush_e),
        .i_rd_wren_e(i_rd_wren_e), .i_mem_wren_e(i_mem_wren_e), .i_wb_sel_e(i_wb_sel_e),
        .i_funct3_e(i_funct3_e), .i_rd_e(i_rd_e), .i_alu_op_e(i_alu_op_e),
        .i_op_a_sel_e(i_op_a_sel_e), .i_op_b_sel_e(i_op_b_sel_e), .i_br_e(i_br_e),
        .i_jmp_e(i_jmp_e), .i_mul_e(i_mul_e), .i_fwd_a_sel(i_fwd_a_sel),
        .i_fwd_b_sel(i_fwd_b_sel), .i_pc_e(i_pc_e), .i_imm_e(i_imm_e),
        .i_rs1_data_e(i_rs1_data_e), .i_rs2_data_e(i_rs2_data_e), .i_wb_data_w(i_wb_data_w),
        .o_rd_wren_m(o_rd_wren_m), .o_mem_wren_m(o_mem_wren_m), .o_wb_sel_m(o_wb_sel_m),
        .o_funct3_m(o_funct3_m), .o_rd_m(o_rd_m), .o_pc_four_m(o_pc_four_m),
        .o_alu_data_m(o_alu_data_m), .o_st_data_m(o_st_data_m), .o_br_taken_e(o_br_taken_e),
        .o_br_target_e(o_br_target_e), .o_busy_e(o_busy_e)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        int unsigned sh;
        logic [63:0] ext;
        sa  = a;
        sb  = b;
        sh  = b % 32;
        ext = {{32{a[31]}}, a} >> sh;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return ext[31:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond_f(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mul_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        logic signed [63:0] sa, sb, p;
        sa = (f != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (f[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    logic        m_rdw, m_memw;
    logic [1:0]  m_wbs;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [31:0] m_pc4, m_alu, m_st, m_mres;
    logic        m_act;
    logic [5:0]  m_cnt;   // cycles elapsed since the multiply was issued

    logic [31:0] m_fa, m_fb, m_opa, m_opb, m_alu_now, m_target;
    logic        m_taken, m_busy, m_done;

    assign m_fa      = (i_fwd_a_sel == 2'b01) ? m_alu : (i_fwd_a_sel == 2'b10) ? i_wb_data_w : i_rs1_data_e;
    assign m_fb      = (i_fwd_b_sel == 2'b01) ? m_alu : (i_fwd_b_sel == 2'b10) ? i_wb_data_w : i_rs2_data_e;
    assign m_opa     = i_op_a_sel_e ? i_pc_e : m_fa;
    assign m_opb     = i_op_b_sel_e ? i_imm_e : m_fb;
    assign m_alu_now = alu_f(i_alu_op_e, m_opa, m_opb);
    assign m_taken   = ((i_br_e && cond_f(i_funct3_e, m_fa, m_fb)) || i_jmp_e) && !i_flush_e;
    assign m_target  = (i_jmp_e && !i_op_a_sel_e) ? (m_alu_now & 32'hFFFF_FFFE) : i_pc_e + i_imm_e;
    assign m_busy    = MUL_ON && ((!m_act && i_mul_e && !i_flush_e) || (m_act && m_cnt <= 6'd32));
    assign m_done    = m_act && (m_cnt == 6'd33);

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_rdw <= 1'b0; m_memw <= 1'b0; m_wbs <= '0; m_f3 <= '0; m_rd <= '0;
            m_pc4 <= '0; m_alu <= '0; m_st <= '0; m_act <= 1'b0; m_cnt <= '0; m_mres <= '0;
        end else begin
            if (!i_stall_e) begin
                if (i_flush_e || m_busy) begin
                    m_rdw <= 1'b0; m_memw <= 1'b0; m_wbs <= '0; m_f3 <= '0; m_rd <= '0;
                    m_pc4 <= '0; m_alu <= '0; m_st <= '0;
                end else begin
                    m_rdw <= i_rd_wren_e; m_memw <= i_mem_wren_e; m_wbs <= i_wb_sel_e;
                    m_f3 <= i_funct3_e; m_rd <= i_rd_e; m_pc4 <= i_pc_e + 32'd4;
                    m_alu <= m_done ? m_mres : m_alu_now;
                    m_st <= m_fb;
                end
            end
            if (i_flush_e) begin
                m_act <= 1'b0;
            end else if (!m_act && i_mul_e && MUL_ON) begin
                m_act  <= 1'b1;
                m_cnt  <= 6'd1;
                m_mres <= mul_f(m_fa, m_fb, i_funct3_e[1:0]);
            end else if (m_act && m_cnt < 6'd33) begin
                m_cnt <= m_cnt + 6'd1;
            end else if (m_act && !i_stall_e) begin
                m_act <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rd_wren_m",  {31'd0, o_rd_wren_m},  {31'd0, m_rdw});
        chk("mem_wren_m", {31'd0, o_mem_wren_m}, {31'd0, m_memw});
        chk("wb_sel_m",   {30'd0, o_wb_sel_m},   {30'd0, m_wbs});
        chk("funct3_m",   {29'd0, o_funct3_m},   {29'd0, m_f3});
        chk("rd_m",       {27'd0, o_rd_m},       {27'd0, m_rd});
        chk("pc_four_m",  o_pc_four_m,  m_pc4);
        chk("alu_data_m", o_alu_data_m, m_alu);
        chk("st_data_m",  o_st_data_m,  m_st);
        chk("br_taken_e", {31'd0, o_br_taken_e}, {31'd0, m_taken});
        chk("br_target_e", o_br_target_e, m_target);
        chk("busy_e",     {31'd0, o_busy_e},     {31'd0, m_busy});
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_in();
        i_stall_e = 0; i_flush_e = 0; i_rd_wren_e = 0; i_mem_wren_e = 0; i_wb_sel_e = '0;
        i_funct3_e = '0; i_rd_e = '0; i_alu_op_e = '0; i_op_a_sel_e = 0; i_op_b_sel_e = 0;
        i_br_e = 0; i_jmp_e = 0; i_mul_e = 0; i_fwd_a_sel = '0; i_fwd_b_sel = '0;
        i_pc_e = '0; i_imm_e = '0; i_rs1_data_e = '0; i_rs2_data_e = '0; i_wb_data_w = '0;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return $urandom_range(31);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_in();
        i_stall_e    = ($urandom_range(7) == 0);
        i_flush_e    = ($urandom_range(15) == 0);
        i_rd_wren_e  = 1'($urandom);
        i_mem_wren_e = 1'($urandom);
        i_wb_sel_e   = 2'($urandom);
        i_funct3_e   = 3'($urandom);
        i_rd_e       = 5'($urandom);
        i_alu_op_e   = 4'($urandom);
        i_op_a_sel_e = 1'($urandom);
        i_op_b_sel_e = 1'($urandom);
        i_br_e       = ($urandom_range(3) == 0);
        i_jmp_e      = ($urandom_range(3) == 0);
        i_mul_e      = ($urandom_range(7) == 0);
        if (i_mul_e) i_funct3_e = {1'b0, 2'($urandom)};
        i_fwd_a_sel  = 2'($urandom);
        i_fwd_b_sel  = 2'($urandom);
        i_pc_e       = $urandom;
        i_imm_e      = pick32();
        i_rs1_data_e = pick32();
        i_rs2_data_e = pick32();
        i_wb_data_w  = pick32();
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic run_mul(input logic [2:0] f3, input logic [31:0] exp);
        int n;
        clr_in();
        i_rs1_data_e = 32'hFFFF_FFFF; i_rs2_data_e = 32'd2; i_funct3_e = f3;
        i_mul_e = 1; i_rd_e = 5'd9; i_rd_wren_e = 1;
        #1;
        n = 0;
        while (o_busy_e === 1'b1 && n < 60) begin
            if (n > 0) chk("mul_bubble", {31'd0, o_rd_wren_m}, 32'd0);
            n++;
            @(posedge i_clk);
            #1;
        end
        chk("mul_busy_len", n, 33);
        chk("mul_done_bubble", {31'd0, o_rd_wren_m}, 32'd0);
        tick();
        chk("mul_result", o_alu_data_m, exp);
        chk("mul_rd", {27'd0, o_rd_m}, 32'd9);
        clr_in();
    endtask
`endif

    initial begin
        int wrote;
        total = 0;
        bad   = 0;
        i_rst = 1'b0;
        clr_in();
        fork
            forever begin
                @(negedge i_clk);
                compare_all();
            end
        join_none
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("reset_alu", o_alu_data_m, 32'd0);
        chk("reset_rdw", {31'd0, o_rd_wren_m}, 32'd0);
        chk("reset_busy", {31'd0, o_busy_e}, 32'd0);

        i_rs1_data_e = 32'h7FFF_FFFF; i_rs2_data_e = 32'd1; i_rd_e = 5'd5; i_rd_wren_e = 1;
        tick();
        chk("add_wrap", o_alu_data_m, 32'h8000_0000);
        chk("add_rd", {27'd0, o_rd_m}, 32'd5);
        i_rs1_data_e = 32'h8000_0000; i_rs2_data_e = 32'd4; i_alu_op_e = 4'd7;
        tick();
        chk("sra", o_alu_data_m, 32'hF800_0000);

        i_rs1_data_e = 32'd2; i_rs2_data_e = 32'd3; i_alu_op_e = 4'd0;
        tick();
        chk("add_5", o_alu_data_m, 32'd5);
        i_rs1_data_e = 32'h0000_DEAD; i_fwd_a_sel = 2'b01; i_alu_op_e = 4'd1;
        tick();
        chk("fwd_a_sub", o_alu_data_m, 32'd2);
        i_fwd_a_sel = 2'b00; i_fwd_b_sel = 2'b10; i_wb_data_w = 32'd9; i_alu_op_e = 4'd0;
        tick();
        chk("fwd_b_st", o_st_data_m, 32'd9);
        chk("fwd_b_alu", o_alu_data_m, 32'h0000_DEB6);

        clr_in();
        i_br_e = 1; i_funct3_e = 3'b100; i_rs1_data_e = 32'hFFFF_FFFF; i_rs2_data_e = 32'd1;
        i_pc_e = 32'h100; i_imm_e = 32'h20;
        #1;
        chk("blt_taken", {31'd0, o_br_taken_e}, 32'd1);
        chk("blt_target", o_br_target_e, 32'h120);
        i_funct3_e = 3'b110;
        #1;
        chk("bltu_not_taken", {31'd0, o_br_taken_e}, 32'd0);
        clr_in();
        i_jmp_e = 1; i_op_b_sel_e = 1; i_rs1_data_e = 32'h203; i_pc_e = 32'h300;
        #1;
        chk("jalr_taken", {31'd0, o_br_taken_e}, 32'd1);
        chk("jalr_target", o_br_target_e, 32'h202);
        tick();
        chk("jalr_pc4", o_pc_four_m, 32'h304);

        clr_in();
        i_rs1_data_e = 32'd10; i_rs2_data_e = 32'd20; i_rd_e = 5'd7; i_rd_wren_e = 1;
        i_wb_sel_e = 2'd2; i_funct3_e = 3'd2;
        tick();
        chk("pre_stall", o_alu_data_m, 32'd30);
        i_stall_e = 1;
        for (int unsigned k = 0; k < 3; k++) begin
            i_rs1_data_e = $urandom; i_rd_e = 5'($urandom);
            tick();
            chk("stall_alu", o_alu_data_m, 32'd30);
            chk("stall_rd", {27'd0, o_rd_m}, 32'd7);
        end
        clr_in();
        i_flush_e = 1; i_rd_wren_e = 1; i_mem_wren_e = 1; i_br_e = 1; i_jmp_e = 1;
        #1;
        chk("flush_no_redirect", {31'd0, o_br_taken_e}, 32'd0);
        tick();
        chk("flush_rdw", {31'd0, o_rd_wren_m}, 32'd0);
        chk("flush_memw", {31'd0, o_mem_wren_m}, 32'd0);
        clr_in();

`ifdef EXECUTE_MUL_EN
        run_mul(3'b000, 32'hFFFF_FFFE);
        run_mul(3'b001, 32'hFFFF_FFFF);
        run_mul(3'b011, 32'h0000_0001);

        i_rs1_data_e = 32'd7; i_rs2_data_e = 32'd5; i_mul_e = 1; i_rd_e = 5'd3; i_rd_wren_e = 1;
        tick();
        repeat (9) tick();
        i_flush_e = 1;
        tick();
        clr_in();
        chk("abort_busy_low", {31'd0, o_busy_e}, 32'd0);
        wrote = 0;
        repeat (40) begin
            tick();
            if (o_alu_data_m == 32'd35) wrote++;
        end
        chk("abort_no_write", wrote, 0);

        i_rs1_data_e = 32'd7; i_rs2_data_e = 32'd5; i_rd_e = 5'd3; i_rd_wren_e = 1;
        i_wb_sel_e = 2'd1; i_pc_e = 32'h40;
        tick();
        i_stall_e = 1; i_mul_e = 1;
        repeat (5) tick();
        chk("run_busy", {31'd0, o_busy_e}, 32'd1);
        chk("run_hold_alu", o_alu_data_m, 32'd12);
        i_mul_e = 0;
        #1 i_rst = 1'b1;
        #1;
        chk("rst_alu", o_alu_data_m, 32'd0);
        chk("rst_pc4", o_pc_four_m, 32'd0);
        chk("rst_rdw", {31'd0, o_rd_wren_m}, 32'd0);
        chk("rst_busy", {31'd0, o_busy_e}, 32'd0);
        i_rst = 1'b0;
        clr_in();
        tick();
`else
        i_rs1_data_e = 32'd3; i_rs2_data_e = 32'd4; i_mul_e = 1; i_rd_e = 5'd2; i_rd_wren_e = 1;
        #1;
        chk("mul_ignored_busy", {31'd0, o_busy_e}, 32'd0);
        tick();
        chk("mul_ignored_alu", o_alu_data_m, 32'd7);
        clr_in();
`endif

        for (int unsigned i = 0; i < 3000; i++) begin
            if (m_act) begin
                i_stall_e = ($urandom_range(3) == 0);
                i_flush_e = ($urandom_range(39) == 0);
            end else begin
                rand_in();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
